// File: rtl/shift_pkg.sv
// Shared encodings for the multi-cycle shifter: op codes, FSM states, op decode helper.
package shift_pkg;

    localparam logic [2:0] OP_LSL = 3'b000;
    localparam logic [2:0] OP_LSR = 3'b001;
    localparam logic [2:0] OP_ASR = 3'b010;
    localparam logic [2:0] OP_ROR = 3'b011;
    localparam logic [2:0] OP_ROL = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Codes above ROL are reserved and behave as a zero-step pass-through.
    function automatic logic op_reserved(input logic [2:0] code);
        return (code > OP_ROL);
    endfunction

endpackage

// File: rtl/shift_step.sv
// Purely combinational single-bit shift/rotate step used by shift_sequencer.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] next_data,
    output logic             shifted_out
);

    always_comb begin
        next_data   = data;
        shifted_out = 1'b0;
        case (op)
            OP_LSL: begin
                next_data   = {data[WIDTH-2:0], 1'b0};
                shifted_out = data[WIDTH-1];
            end
            OP_LSR: begin
                next_data   = {1'b0, data[WIDTH-1:1]};
                shifted_out = data[0];
            end
            OP_ASR: begin
                next_data   = {data[WIDTH-1], data[WIDTH-1:1]};
                shifted_out = data[0];
            end
            OP_ROR: begin
                next_data   = {data[0], data[WIDTH-1:1]};
                shifted_out = data[0];
            end
            OP_ROL: begin
                next_data   = {data[WIDTH-2:0], data[WIDTH-1]};
                shifted_out = data[WIDTH-1];
            end
            default: begin
                next_data   = data;
                shifted_out = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: accepts one request in IDLE, applies one bit step per clock,
// then pulses done for one cycle with the result held in data_out/carry_out.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amount,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_out,
    output logic             carry_out
);

    state_t           state;
    state_t           state_next;
    logic [AMT_W-1:0] cnt;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] step_data;
    logic             step_bit;

    shift_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .data       (data_out),
        .op         (op_q),
        .next_data  (step_data),
        .shifted_out(step_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_SHIFT;
            ST_SHIFT: if (cnt == '0) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out  <= '0;
            carry_out <= 1'b0;
            cnt       <= '0;
            op_q      <= '0;
        end else if (state == ST_IDLE && start) begin
            data_out  <= data_in;
            op_q      <= op;
            carry_out <= 1'b0;
            cnt       <= op_reserved(op) ? '0 : amount;
        end else if (state == ST_SHIFT && cnt != '0) begin
            data_out  <= step_data;
            carry_out <= step_bit;
            cnt       <= cnt - AMT_W'(1);
        end
    end

    // Status is a pure decode of the state register, so no input reaches an output.
    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

endmodule
